// File: rtl/berger_scrub_memory_if.sv
// Host-side bus of berger_scrub_memory: write, read, fault injection and error log.
interface berger_scrub_memory_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic [AW-1:0]     input_addr;
    logic [DATA_W-1:0] input_data;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              inj_en;
    logic [AW-1:0]     inj_addr;
    logic [DATA_W-1:0] inj_mask;
    logic              err_clr;
    logic [CNT_W-1:0]  err_count;
    logic              err_sticky;
    logic [AW-1:0]     err_addr;
    logic [AW-1:0]     scrub_addr;

    modport master (
        output wr_en, input_addr, input_data, rd_en, rd_addr,
               inj_en, inj_addr, inj_mask, err_clr,
        input  rd_data, rd_valid, rd_err, err_count, err_sticky, err_addr, scrub_addr
    );

    modport slave (
        input  wr_en, input_addr, input_data, rd_en, rd_addr,
               inj_en, inj_addr, inj_mask, err_clr,
        output rd_data, rd_valid, rd_err, err_count, err_sticky, err_addr, scrub_addr
    );
endinterface

// File: rtl/berger_scrub_memory.sv
// Berger zero-count protected memory with a registered read port, an idle-time
// background scrubber that only detects, and a saturating error log.
module berger_scrub_memory #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 16,
    parameter int SCRUB_INTERVAL = 64,
    parameter bit SCRUB_EN       = 1'b1,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    berger_scrub_memory_if.slave  bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(SCRUB_INTERVAL);

    localparam logic [AW:0]    DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TW-1:0]  LAST_TICK = TW'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_WAIT, S_PEND, S_CHECK} scrub_state_t;

    function automatic logic [CW-1:0] zero_count(input logic [DATA_W-1:0] d);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) n = n + CW'(~d[i]);
        return n;
    endfunction

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CW-1:0]     mem_chk  [DEPTH];

    // NOTE: the array sits in flops with async reset because every entry must
    // power up as the valid codeword of zero; a RAM macro could not do that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_chk[i]  <= CW'(DATA_W);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr_en && bus.input_addr == AW'(i)) begin
                    mem_data[i] <= bus.input_data;
                    mem_chk[i]  <= zero_count(bus.input_data);
                end else if (bus.inj_en && bus.inj_addr == AW'(i)) begin
                    mem_data[i] <= mem_data[i] | bus.inj_mask;
                end
            end
        end
    end

    logic [DATA_W-1:0] rd_word;
    logic              rd_word_err;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        rd_word     = '0;
        rd_word_err = 1'b0;
        if ({1'b0, bus.rd_addr} < DEPTH_EXT) begin
            rd_word     = mem_data[bus.rd_addr];
            rd_word_err = zero_count(mem_data[bus.rd_addr]) != mem_chk[bus.rd_addr];
        end
    end

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic [AW-1:0]     rd_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_word;
                rd_err_q  <= rd_word_err;
                rd_addr_q <= bus.rd_addr;
            end
        end
    end

    scrub_state_t      state;
    logic [TW-1:0]     tick;
    logic [AW-1:0]     scrub_addr_q;
    logic [DATA_W-1:0] scrub_data_q;
    logic [CW-1:0]     scrub_chk_q;

    // The scrubber only steals cycles with no host access, so its check never
    // coincides with a user-read check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_WAIT;
            tick         <= '0;
            scrub_addr_q <= '0;
            scrub_data_q <= '0;
            scrub_chk_q  <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (SCRUB_EN) begin
                        if (tick == LAST_TICK) state <= S_PEND;
                        else                   tick  <= tick + 1'b1;
                    end
                end
                S_PEND: begin
                    if (!bus.wr_en && !bus.rd_en) begin
                        scrub_data_q <= mem_data[scrub_addr_q];
                        scrub_chk_q  <= mem_chk[scrub_addr_q];
                        state        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state        <= S_WAIT;
                    tick         <= '0;
                    scrub_addr_q <= (scrub_addr_q == LAST_ADDR) ? '0 : scrub_addr_q + 1'b1;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    logic          log_hit;
    logic [AW-1:0] log_addr;

    always_comb begin
        log_hit  = 1'b0;
        log_addr = rd_addr_q;
        if (rd_valid_q && rd_err_q) begin
            log_hit = 1'b1;
        end else if (state == S_CHECK && zero_count(scrub_data_q) != scrub_chk_q) begin
            log_hit  = 1'b1;
            log_addr = scrub_addr_q;
        end
    end

    logic [CNT_W-1:0] err_count_q;
    logic             err_sticky_q;
    logic [AW-1:0]    err_addr_q;

    // A detected error outranks a simultaneous clear: it restarts the log at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (log_hit) begin
            if (bus.err_clr)               err_count_q <= CNT_W'(1);
            else if (err_count_q != CNT_MAX) err_count_q <= err_count_q + 1'b1;
            err_sticky_q <= 1'b1;
            if (!err_sticky_q || bus.err_clr) err_addr_q <= log_addr;
        end else if (bus.err_clr) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.scrub_addr = scrub_addr_q;
endmodule
